// File: rtl/tawas_rcn_pkg.sv
// rtl/tawas_rcn_pkg.sv - request/tag-table types and lane-extract helper for the RCN master
package tawas_rcn_pkg;

  typedef struct packed {
    logic        xch;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  wbreg;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } rcn_req_t;

  typedef struct packed {
    logic       busy;
    logic       need_wb;
    logic [2:0] wbreg;
    logic [3:0] mask;
  } rcn_tag_t;

  typedef enum logic {
    ISS_IDLE,
    ISS_HOLD
  } rcn_iss_state_t;

  // Response words arrive with lanes in place; move the addressed lanes down.
  function automatic logic [31:0] rcn_lane_extract(logic [3:0] mask, logic [31:0] data);
    logic [31:0] r;
    case (mask)
      4'b0011: r = {16'h0000, data[15:0]};
      4'b1100: r = {16'h0000, data[31:16]};
      4'b0001: r = {24'h000000, data[7:0]};
      4'b0010: r = {24'h000000, data[15:8]};
      4'b0100: r = {24'h000000, data[23:16]};
      4'b1000: r = {24'h000000, data[31:24]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tawas_rcn_master_if.sv
// rtl/tawas_rcn_master_if.sv - RCN bus request and response channels
interface tawas_rcn_master_if #(
  parameter int TAG_W = 2
);
  logic             breq_vld;
  logic             breq_rdy;
  logic             breq_wr;
  logic             breq_xch;
  logic [31:0]      breq_addr;
  logic [3:0]       breq_mask;
  logic [31:0]      breq_wdata;
  logic [TAG_W-1:0] breq_tag;
  logic             brsp_vld;
  logic [TAG_W-1:0] brsp_tag;
  logic [31:0]      brsp_data;

  modport master (
    output breq_vld, breq_wr, breq_xch, breq_addr, breq_mask, breq_wdata, breq_tag,
    input  breq_rdy, brsp_vld, brsp_tag, brsp_data
  );

  modport slave (
    input  breq_vld, breq_wr, breq_xch, breq_addr, breq_mask, breq_wdata, breq_tag,
    output breq_rdy, brsp_vld, brsp_tag, brsp_data
  );
endinterface

// File: rtl/tawas_rcn_fifo.sv
// rtl/tawas_rcn_fifo.sv - generic synchronous FIFO with occupancy count
module tawas_rcn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/tawas_rcn_master.sv
// rtl/tawas_rcn_master.sv - RCN request queue, tagged bus issue, response tracking and writeback
// Define TAWAS_RCN_ERR_CAPTURE_EN to add sticky rcn_err / rcn_err_addr capture.
module tawas_rcn_master
  import tawas_rcn_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rcn_cs,
  input  logic                    rcn_xch,
  input  logic                    rcn_wr,
  input  logic [31:0]             rcn_addr,
  input  logic [2:0]              rcn_wbreg,
  input  logic [3:0]              rcn_mask,
  input  logic [31:0]             rcn_wdata,
  output logic                    rcn_full,
  tawas_rcn_master_if.master      bus,
  output logic                    wb_rcn_en,
  output logic [2:0]              wb_rcn_reg,
  output logic [31:0]             wb_rcn_data,
  output logic                    rcn_idle
`ifdef TAWAS_RCN_ERR_CAPTURE_EN
  ,
  output logic                    rcn_err,
  output logic [31:0]             rcn_err_addr
`endif
);
  localparam int NT = 1 << TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rcn_req_t        fifo_wdata;
  rcn_req_t        head;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push_ok;
  logic [CW-1:0]   count_nxt;

  rcn_tag_t        tt [NT];
  logic [NT-1:0]   busy;
  logic [NT-1:0]   busy_nxt;
  logic [TAG_W:0]  free_cnt_nxt;
  logic [TAG_W-1:0] free_tag;
  logic            free_any;

  rcn_iss_state_t  iss_state;
  rcn_iss_state_t  iss_state_nxt;
  logic [TAG_W-1:0] hold_tag;
  logic [TAG_W-1:0] hold_tag_nxt;
  logic [TAG_W-1:0] iss_tag;
  logic            iss_vld;
  logic            issue;
  logic            rsp_hit;

  assign fifo_wdata = '{xch: rcn_xch, wr: rcn_wr, addr: rcn_addr, wbreg: rcn_wbreg,
                        mask: rcn_mask, wdata: rcn_wdata};

  tawas_rcn_fifo #(
    .WIDTH ($bits(rcn_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rcn_cs),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    for (int i = 0; i < NT; i++) busy[i] = tt[i].busy;
  end

  always_comb begin
    free_tag = '0;
    free_any = 1'b0;
    for (int i = NT - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_tag = TAG_W'(i);
        free_any = 1'b1;
      end
    end
  end

  // Once a tag is offered it is held until accepted, even if a lower tag frees meanwhile.
  always_comb begin
    iss_state_nxt = iss_state;
    hold_tag_nxt  = hold_tag;
    iss_vld       = 1'b0;
    iss_tag       = free_tag;
    case (iss_state)
      ISS_IDLE: begin
        if (!fifo_empty && free_any) begin
          iss_vld = 1'b1;
          if (!bus.breq_rdy) begin
            iss_state_nxt = ISS_HOLD;
            hold_tag_nxt  = free_tag;
          end
        end
      end
      ISS_HOLD: begin
        iss_vld = 1'b1;
        iss_tag = hold_tag;
        if (bus.breq_rdy) iss_state_nxt = ISS_IDLE;
      end
      default: iss_state_nxt = ISS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_state <= ISS_IDLE;
      hold_tag  <= '0;
    end else begin
      iss_state <= iss_state_nxt;
      hold_tag  <= hold_tag_nxt;
    end
  end

  assign bus.breq_vld   = iss_vld;
  assign bus.breq_tag   = iss_tag;
  assign bus.breq_wr    = head.wr;
  assign bus.breq_xch   = head.xch;
  assign bus.breq_addr  = head.addr;
  assign bus.breq_mask  = head.mask;
  assign bus.breq_wdata = head.wdata;

  assign issue    = iss_vld && bus.breq_rdy;
  assign fifo_pop = issue;
  assign rsp_hit  = bus.brsp_vld && busy[bus.brsp_tag];
  assign push_ok  = rcn_cs && (!fifo_full || fifo_pop);
  assign count_nxt = fifo_count + CW'(push_ok) - CW'(fifo_pop);

  always_comb begin
    busy_nxt = busy;
    if (rsp_hit) busy_nxt[bus.brsp_tag] = 1'b0;
    if (issue)   busy_nxt[iss_tag]      = 1'b1;
    free_cnt_nxt = '0;
    for (int i = 0; i < NT; i++) free_cnt_nxt = free_cnt_nxt + (TAG_W+1)'(!busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NT; i++) tt[i] <= '0;
      rcn_full    <= 1'b0;
      wb_rcn_en   <= 1'b0;
      wb_rcn_reg  <= '0;
      wb_rcn_data <= '0;
    end else begin
      // Flag is computed from post-edge occupancy so it leads the issue stage by one op.
      rcn_full  <= (count_nxt >= CW'(FIFO_DEPTH - 1)) || (free_cnt_nxt <= (TAG_W+1)'(1));
      wb_rcn_en <= rsp_hit && tt[bus.brsp_tag].need_wb;
      if (rsp_hit) begin
        tt[bus.brsp_tag].busy <= 1'b0;
        wb_rcn_reg  <= tt[bus.brsp_tag].wbreg;
        wb_rcn_data <= rcn_lane_extract(tt[bus.brsp_tag].mask, bus.brsp_data);
      end
      if (issue) begin
        tt[iss_tag] <= '{busy: 1'b1, need_wb: !head.wr || head.xch,
                         wbreg: head.wbreg, mask: head.mask};
      end
    end
  end

  assign rcn_idle = fifo_empty && (busy == '0);

`ifdef TAWAS_RCN_ERR_CAPTURE_EN
  logic push_drop;
  assign push_drop = rcn_cs && !push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      rcn_err      <= 1'b0;
      rcn_err_addr <= '0;
    end else if (bus.brsp_vld && !busy[bus.brsp_tag]) begin
      rcn_err      <= 1'b1;
      rcn_err_addr <= 32'hFFFF_FFFF;
    end else if (push_drop) begin
      rcn_err      <= 1'b1;
      rcn_err_addr <= rcn_addr;
    end
  end
`endif

endmodule

// File: tb/tb_tawas_rcn_master.sv
// tb/tb_tawas_rcn_master.sv - randomized and directed bench for tawas_rcn_master against a queue model
module tb_tawas_rcn_master;
  localparam int FIFO_DEPTH = 4;
  localparam int TAG_W      = 2;
  localparam int NT         = 1 << TAG_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        rcn_cs, rcn_xch, rcn_wr;
  logic [31:0] rcn_addr;
  logic [2:0]  rcn_wbreg;
  logic [3:0]  rcn_mask;
  logic [31:0] rcn_wdata;
  logic        rcn_full;
  logic        wb_rcn_en;
  logic [2:0]  wb_rcn_reg;
  logic [31:0] wb_rcn_data;
  logic        rcn_idle;
`ifdef TAWAS_RCN_ERR_CAPTURE_EN
  logic        rcn_err;
  logic [31:0] rcn_err_addr;
`endif

  tawas_rcn_master_if #(.TAG_W(TAG_W)) bus ();

  always #5 clk = ~clk;

  tawas_rcn_master #(.FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .rcn_cs      (rcn_cs),
    .rcn_xch     (rcn_xch),
    .rcn_wr      (rcn_wr),
    .rcn_addr    (rcn_addr),
    .rcn_wbreg   (rcn_wbreg),
    .rcn_mask    (rcn_mask),
    .rcn_wdata   (rcn_wdata),
    .rcn_full    (rcn_full),
    .bus         (bus),
    .wb_rcn_en   (wb_rcn_en),
    .wb_rcn_reg  (wb_rcn_reg),
    .wb_rcn_data (wb_rcn_data),
    .rcn_idle    (rcn_idle)
`ifdef TAWAS_RCN_ERR_CAPTURE_EN
    ,
    .rcn_err     (rcn_err),
    .rcn_err_addr(rcn_err_addr)
`endif
  );

  typedef struct {
    logic        xch;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  wbreg;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mreq_t;

  mreq_t       q[$];
  bit          m_busy [NT];
  bit          m_need [NT];
  logic [2:0]  m_reg  [NT];
  logic [3:0]  m_mask [NT];
  bit          held;
  int          held_tag;
  bit          e_wb;
  logic [2:0]  e_wb_reg;
  logic [31:0] e_wb_data;
  bit          e_err;
  logic [31:0] e_err_addr;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int free_count();
    int n = 0;
    for (int i = 0; i < NT; i++) if (!m_busy[i]) n++;
    return n;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
    return 0;
  endfunction

  function automatic bit exp_vld();
    return (q.size() > 0) && (held || free_count() > 0);
  endfunction

  function automatic int exp_tag();
    return held ? held_tag : lowest_free();
  endfunction

  function automatic bit model_full();
    return (q.size() >= FIFO_DEPTH - 1) || (free_count() <= 1);
  endfunction

  // Selected lanes = contiguous run starting at the lowest set mask bit.
  function automatic logic [31:0] lanes(input logic [3:0] mask, input logic [31:0] d);
    int lo = 0;
    int n = 0;
    logic [63:0] w;
    for (int i = 3; i >= 0; i--) if (mask[i]) lo = i;
    for (int i = 0; i < 4; i++) if (mask[i]) n++;
    w = 64'(d) >> (8 * lo);
    return 32'(w & ((64'd1 << (8 * n)) - 64'd1));
  endfunction

  task automatic check_outputs();
    bit v;
    v = exp_vld();
    check("breq_vld", 32'(bus.breq_vld), 32'(v));
    if (v && bus.breq_vld) begin
      check("breq_tag",   32'(bus.breq_tag),  32'(exp_tag()));
      check("breq_addr",  bus.breq_addr,       q[0].addr);
      check("breq_wr",    32'(bus.breq_wr),    32'(q[0].wr));
      check("breq_xch",   32'(bus.breq_xch),   32'(q[0].xch));
      check("breq_mask",  32'(bus.breq_mask),  32'(q[0].mask));
      check("breq_wdata", bus.breq_wdata,      q[0].wdata);
    end
    check("wb_en", 32'(wb_rcn_en), 32'(e_wb));
    if (e_wb) begin
      check("wb_reg",  32'(wb_rcn_reg), 32'(e_wb_reg));
      check("wb_data", wb_rcn_data,     e_wb_data);
    end
    check("rcn_full", 32'(rcn_full), 32'(model_full()));
    check("rcn_idle", 32'(rcn_idle), 32'(q.size() == 0 && free_count() == NT));
`ifdef TAWAS_RCN_ERR_CAPTURE_EN
    check("rcn_err", 32'(rcn_err), 32'(e_err));
    if (e_err) check("rcn_err_addr", rcn_err_addr, e_err_addr);
`endif
  endtask

  task automatic tick();
    bit v;
    int t;
    mreq_t r;
    v = exp_vld();
    t = exp_tag();
    @(posedge clk);
    if (rst) begin
      q.delete();
      for (int i = 0; i < NT; i++) m_busy[i] = 0;
      held  = 0;
      e_wb  = 0;
      e_err = 0;
    end else begin
      e_wb = 0;
      if (bus.brsp_vld) begin
        if (m_busy[bus.brsp_tag]) begin
          m_busy[bus.brsp_tag] = 0;
          if (m_need[bus.brsp_tag]) begin
            e_wb      = 1;
            e_wb_reg  = m_reg[bus.brsp_tag];
            e_wb_data = lanes(m_mask[bus.brsp_tag], bus.brsp_data);
          end
        end else begin
          e_err      = 1;
          e_err_addr = 32'hFFFF_FFFF;
        end
      end
      if (v && bus.breq_rdy) begin
        m_busy[t] = 1;
        m_need[t] = !q[0].wr || q[0].xch;
        m_reg[t]  = q[0].wbreg;
        m_mask[t] = q[0].mask;
        void'(q.pop_front());
        held = 0;
      end else if (v) begin
        held     = 1;
        held_tag = t;
      end
      if (rcn_cs) begin
        if (q.size() < FIFO_DEPTH) begin
          r = '{xch: rcn_xch, wr: rcn_wr, addr: rcn_addr, wbreg: rcn_wbreg,
                mask: rcn_mask, wdata: rcn_wdata};
          q.push_back(r);
        end else begin
          e_err      = 1;
          e_err_addr = rcn_addr;
        end
      end
    end
    @(negedge clk);
    rcn_cs       = 1'b0;
    bus.brsp_vld = 1'b0;
    check_outputs();
  endtask

  task automatic send(input bit xch, input bit wr, input logic [31:0] addr,
                      input logic [2:0] wbreg, input logic [3:0] mask, input logic [31:0] wdata);
    rcn_cs    = 1'b1;
    rcn_xch   = xch;
    rcn_wr    = wr;
    rcn_addr  = addr;
    rcn_wbreg = wbreg;
    rcn_mask  = mask;
    rcn_wdata = wdata;
  endtask

  task automatic respond(input int tag, input logic [31:0] data);
    bus.brsp_vld  = 1'b1;
    bus.brsp_tag  = TAG_W'(tag);
    bus.brsp_data = data;
  endtask

  task automatic drain();
    int busy_list[$];
    bus.breq_rdy = 1'b1;
    for (int c = 0; c < 100 && !(q.size() == 0 && free_count() == NT); c++) begin
      busy_list.delete();
      for (int i = 0; i < NT; i++) if (m_busy[i]) busy_list.push_back(i);
      if (busy_list.size() > 0)
        respond(busy_list[$urandom_range(0, busy_list.size() - 1)], $urandom);
      tick();
    end
    check("drain_idle", 32'(rcn_idle), 32'd1);
  endtask

  task automatic do_read(input string name, input logic [3:0] mask, input logic [31:0] data,
                         input logic [31:0] want);
    send(0, 0, 32'h8000_0020, 3'd4, mask, 32'h0);
    tick();
    tick();
    respond(0, data);
    tick();
    check({name, "_wb_en"}, 32'(wb_rcn_en), 32'd1);
    check({name, "_wb_data"}, wb_rcn_data, want);
    tick();
  endtask

  logic [3:0]  mask_tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [31:0] hold_addr;
  logic [TAG_W-1:0] hold_t;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    send(0, 0, 32'h8000_0000, 3'd0, 4'hF, 32'h0);
    rcn_cs = 1'b0;
    bus.breq_rdy  = 1'b0;
    bus.brsp_vld  = 1'b0;
    bus.brsp_tag  = '0;
    bus.brsp_data = '0;
    held = 0; held_tag = 0; e_wb = 0; e_err = 0; e_err_addr = '0;
    e_wb_reg = '0; e_wb_data = '0;
    for (int i = 0; i < NT; i++) begin
      m_busy[i] = 0; m_need[i] = 0; m_reg[i] = '0; m_mask[i] = '0;
    end

    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_idle", 32'(rcn_idle), 32'd1);
    check("rst_full", 32'(rcn_full), 32'd0);

    // Word read
    bus.breq_rdy = 1'b1;
    send(0, 0, 32'h8000_0010, 3'd5, 4'hF, 32'h0);
    tick();
    check("word_vld_n1", 32'(bus.breq_vld), 32'd1);
    check("word_tag", 32'(bus.breq_tag), 32'd0);
    tick();
    tick();
    tick();
    respond(0, 32'hDEAD_BEEF);
    tick();
    check("word_wb_en", 32'(wb_rcn_en), 32'd1);
    check("word_wb_reg", 32'(wb_rcn_reg), 32'd5);
    check("word_wb_data", wb_rcn_data, 32'hDEAD_BEEF);
    tick();
    check("word_idle", 32'(rcn_idle), 32'd1);

    do_read("byte2", 4'b0100, 32'h1122_3344, 32'h0000_0022);
    do_read("half1", 4'b1100, 32'h1122_3344, 32'h0000_1122);
    do_read("half0", 4'b0011, 32'h1122_3344, 32'h0000_3344);
    do_read("byte3", 4'b1000, 32'h1122_3344, 32'h0000_0011);

    // Four back-to-back reads plus a fifth parked in the FIFO
    for (int k = 0; k < 5; k++) begin
      send(0, 0, 32'h8000_0100 + 32'(k * 4), 3'(k), 4'hF, 32'h0);
      tick();
      if (k == 2) check("four_full_pre", 32'(rcn_full), 32'd0);
      if (k == 3) check("four_full_post3", 32'(rcn_full), 32'd1);
    end
    check("fifth_parked_vld", 32'(bus.breq_vld), 32'd0);
    check("fifth_parked_idle", 32'(rcn_idle), 32'd0);
    respond(2, 32'h0000_00AA);
    tick();
    check("fifth_vld", 32'(bus.breq_vld), 32'd1);
    check("fifth_tag", 32'(bus.breq_tag), 32'd2);
    tick();
    drain();

    // Write then exchange
    send(0, 1, 32'h8000_0200, 3'd2, 4'hF, 32'h5555_AAAA);
    tick();
    check("write_breq_wr", 32'(bus.breq_wr), 32'd1);
    tick();
    respond(0, 32'h1234_5678);
    tick();
    check("write_no_wb", 32'(wb_rcn_en), 32'd0);
    send(1, 1, 32'h8000_0204, 3'd3, 4'hF, 32'h0F0F_0F0F);
    tick();
    check("xch_breq_xch", 32'(bus.breq_xch), 32'd1);
    tick();
    respond(0, 32'hCAFE_F00D);
    tick();
    check("xch_wb_en", 32'(wb_rcn_en), 32'd1);
    check("xch_wb_reg", 32'(wb_rcn_reg), 32'd3);

    // Stall with two queued, then out-of-order responses
    bus.breq_rdy = 1'b0;
    send(0, 0, 32'h8000_0300, 3'd1, 4'hF, 32'h0);
    tick();
    send(0, 0, 32'h8000_0304, 3'd6, 4'hF, 32'h0);
    tick();
    hold_addr = bus.breq_addr;
    hold_t    = bus.breq_tag;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_addr", bus.breq_addr, 32'h8000_0300);
      check("stall_tag", 32'(bus.breq_tag), 32'(hold_t));
    end
    check("stall_first_addr", hold_addr, 32'h8000_0300);
    bus.breq_rdy = 1'b1;
    tick();
    tick();
    respond(1, 32'h0000_0011);
    tick();
    check("ooo_first_reg", 32'(wb_rcn_reg), 32'd6);
    respond(0, 32'h0000_0022);
    tick();
    check("ooo_second_reg", 32'(wb_rcn_reg), 32'd1);
    tick();

    // Reset with two tags outstanding, then a stale response
    send(0, 0, 32'h8000_0400, 3'd2, 4'hF, 32'h0);
    tick();
    send(0, 0, 32'h8000_0404, 3'd3, 4'hF, 32'h0);
    tick();
    tick();
    check("pre_rst_busy", 32'(rcn_idle), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    respond(0, 32'h7777_7777);
    tick();
    check("stale_no_wb", 32'(wb_rcn_en), 32'd0);
    check("stale_idle", 32'(rcn_idle), 32'd1);
`ifdef TAWAS_RCN_ERR_CAPTURE_EN
    check("stale_err", 32'(rcn_err), 32'd1);
    check("stale_err_addr", rcn_err_addr, 32'hFFFF_FFFF);
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      int r;
      int kind;
      int busy_list[$];
      bus.breq_rdy = ($urandom_range(0, 9) < 7);
      if (!model_full() && $urandom_range(0, 1) == 1) begin
        kind = $urandom_range(0, 2);
        send(kind == 2, kind != 0, {1'b1, 31'($urandom)}, 3'($urandom),
             mask_tab[$urandom_range(0, 6)], $urandom);
      end
      r = $urandom_range(0, 99);
      busy_list.delete();
      for (int i = 0; i < NT; i++) if (m_busy[i]) busy_list.push_back(i);
      if (r < 40 && busy_list.size() > 0)
        respond(busy_list[$urandom_range(0, busy_list.size() - 1)], $urandom);
      else if (r >= 97)
        respond($urandom_range(0, NT - 1), $urandom);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tawas_rcn_master.md
Name: tawas_rcn_master

Overview:
- Downstream of the load/store stage. Consumes its registered RCN request strobe and fields: rcn_cs, rcn_xch, rcn_wr, rcn_addr, rcn_wbreg, rcn_mask, rcn_wdata.
- Buffers requests, tags them, issues them on a valid/ready bus request channel, and tracks them until each response arrives.
- Returns load/exchange data to the register file as a third writeback port, alongside the pointer and store writebacks.
- Drives a backpressure flag to the issue logic.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, at least 2.
- TAG_W, 2, tag width; 2**TAG_W outstanding transactions max.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rcn_cs  in  1  request strobe from load/store stage
- rcn_xch  in  1  exchange: write data, return old value
- rcn_wr  in  1  write
- rcn_addr  in  32  byte address; bit 31 is always 1
- rcn_wbreg  in  3  destination register
- rcn_mask  in  4  byte-lane mask
- rcn_wdata  in  32  lane-replicated write data
- rcn_full  out  1  issue must not launch another RCN op
- breq_vld  out  1  bus request valid
- breq_rdy  in  1  bus request ready
- breq_wr  out  1  write
- breq_xch  out  1  exchange
- breq_addr  out  32  address
- breq_mask  out  4  mask
- breq_wdata  out  32  write data
- breq_tag  out  TAG_W  transaction tag
- brsp_vld  in  1  response valid; always accepted
- brsp_tag  in  TAG_W  response tag
- brsp_data  in  32  read data; full word, lanes in place
- wb_rcn_en  out  1  register writeback enable
- wb_rcn_reg  out  3  writeback register
- wb_rcn_data  out  32  writeback data, zero-extended
- rcn_idle  out  1  FIFO empty and no tags outstanding

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFO empty, all tags free.
  - breq_vld=0, wb_rcn_en=0, rcn_full=0, rcn_idle=1.
  - Data outputs are don't-care; the bench checks them only when qualified.
  - Reset mid-transaction drops all outstanding state. Later responses with stale tags are ignored.
- Enqueue:
  - rcn_cs=1 at edge N writes one FIFO entry.
  - Earliest breq_vld is at N+1.
- rcn_full is registered. It is 1 when either:
  - FIFO count >= FIFO_DEPTH-1, or
  - free tag count <= 1.
  - The one-entry margin covers the issue-to-rcn_cs register stage.
- Overflow: rcn_cs while the FIFO is truly full drops the request. See the optional feature.
- Issue:
  - breq_vld=1 requires FIFO non-empty and at least one free tag.
  - Tag is the lowest-numbered free tag, chosen when breq_vld rises.
  - All breq_* fields hold stable while breq_vld=1 and breq_rdy=0.
  - On vld&rdy:
    - FIFO pops.
    - The tag table records {busy=1, wbreg, mask, need_wb = !wr | xch}.
    - Back-to-back issue: one request per cycle.
- Response:
  - brsp_vld=1 with brsp_tag busy frees the tag at that edge.
  - If need_wb is set, wb_rcn_en=1 on the next cycle (1-cycle latency), with wb_rcn_reg=wbreg.
  - Plain writes free the tag with no writeback.
  - Response with a non-busy tag: ignored, no writeback.
- Data extraction by the stored mask:
  - 1111: full word.
  - 0011: data[15:0].
  - 1100: data[31:16].
  - 0001/0010/0100/1000: corresponding byte.
  - All results are zero-extended.
- Simultaneous events:
  - Response freeing tag T and an issue in the same cycle: T is not reusable until the next cycle. Allocation uses the pre-edge free vector.
  - Enqueue and pop in the same cycle: count unchanged.
- Responses may arrive in any order. wb_rcn_en is at most one per cycle because brsp is single-ported.
- rcn_idle is combinational from the FIFO count and the busy vector.

Optional Feature:
- Macro: TAWAS_RCN_ERR_CAPTURE_EN.
- Defined:
  - Adds outputs rcn_err (1) and rcn_err_addr (32).
  - A dropped overflow request or an unknown-tag response sets sticky rcn_err and records the address. For an unknown tag, the recorded address is 0xFFFFFFFF.
  - Only rst clears them.
- Undefined: ports absent; drops and ignored responses are silent.

Decomposition:
- Package tawas_rcn_pkg holds:
  - the request entry struct {xch, wr, addr, wbreg, mask, wdata};
  - the tag-table entry struct;
  - the lane-extract function (mask, data) -> data.
- Sub-module tawas_rcn_fifo: generic synchronous FIFO, parameterized width/depth. Ports: push, pop, full, empty, count.
- Tag table, allocator and writeback register stay in this module.

Test Plan:
- Word read, rcn_addr=0x80000010, mask=F, wbreg=5, breq_rdy=1, response data 0xDEADBEEF on tag 0, 3 cycles later -> breq_vld at N+1 with tag 0; wb_rcn_en one cycle after brsp with reg 5, data 0xDEADBEEF; rcn_idle returns to 1.
- Byte read, mask=0100, response data 0x11223344 -> wb data 0x00000022. Half read, mask=1100 -> 0x00001122.
- Four reads back-to-back, rdy=1, no responses -> tags 0,1,2,3 issued; rcn_full=1 after the third issue; a fifth request sits in the FIFO with breq_vld=0. Response on tag 2 -> the fifth issues with tag 2 the following cycle.
- Write, mask=F -> breq_wr=1; response produces no wb. Exchange, mask=F, wbreg=3 -> breq_xch=1 and a writeback to reg 3.
- breq_rdy=0 for 5 cycles with 2 queued -> fields stable throughout; order is preserved after rdy rises. Out-of-order responses (tag 1 before tag 0) -> writebacks follow response order with the correct regs.
- Reset asserted with 2 tags outstanding, then a response for tag 0 -> no writeback; rcn_idle=1. With TAWAS_RCN_ERR_CAPTURE_EN, rcn_err=1.
